pop_sequence_monitor: RTL and testbench
=======================================

// Module: pop_sequence_monitor
// PURPOSE
//  Receive-side checker for the POP timing outputs (pump, MW, probe, sample) on the 2.5 MHz domain.
//  Decodes one pump -> MW(pi/2) -> free precession -> MW(pi/2) -> probe sequence per cycle.
//  Measures every pulse width and the precession gap in clock cycles.
//  Reports the measurements with a one-cycle valid strobe, or flags ordering, overlap or timeout errors.
// PARAMETERS
//  WIDTH    16     width of all length counters and outputs
//  TIMEOUT  20000  max dwell (cycles) in any non-IDLE state; must be <= 2**WIDTH-1
// PORTS
//  clk_2M5          in   1      2.5 MHz clock; the only clock
//  reset            in   1      reset, synchronous, active-low
//  pump             in   1      pump pulse under test
//  MW               in   1      MW pulse under test (two per sequence)
//  probe            in   1      probe pulse under test
//  sample           in   1      sample strobe; counted only while probe is high
//  pump_len         out  WIDTH  cycles pump was high
//  pieovertwo_len   out  WIDTH  cycles of the first MW pulse
//  freeprecess_len  out  WIDTH  cycles from first MW fall to second MW rise
//  mw2_len          out  WIDTH  cycles of the second MW pulse
//  probe_len        out  WIDTH  cycles probe was high
//  sample_count     out  8      sample rising edges seen during probe; saturates at 255
//  meas_valid       out  1      1-cycle pulse: all *_len and sample_count updated together
//  seq_error        out  1      1-cycle pulse on any error
//  error_code       out  2      0 none, 1 order/unexpected edge, 2 overlap, 3 timeout
//  good_count       out  WIDTH  count of valid sequences; wraps
// BEHAVIOUR
//  Reset (reset==0 at a clk edge):
//   - all outputs 0; FSM -> IDLE; counters 0.
//   - Edge-history registers load the current registered inputs, so a level held through reset gives no edge.
//  Input path:
//   - All four inputs go through one register stage; edges = registered value vs history register.
//   - Length = number of clk edges at which the registered input was high (gaps: low).
//   - Length counters saturate at 2**WIDTH-1.
//  FSM states and transitions:
//   - IDLE -> PUMP on pump rise; every other edge is ignored in IDLE.
//   - PUMP -> GAP1 on pump fall.
//   - GAP1 -> MW1 on MW rise.
//   - MW1 -> PRECESS on MW fall.
//   - PRECESS -> MW2 on MW rise.
//   - MW2 -> GAP2 on MW fall.
//   - GAP2 -> PROBE on probe rise.
//   - PROBE -> REPORT on probe fall.
//   - REPORT (1 cycle): drive meas_valid=1, load outputs, good_count+1, clear error_code -> IDLE.
//  Latency: meas_valid rises at the 2nd clk edge after probe is first sampled low at the pin.
//  Errors (outside IDLE; evaluated every cycle; priority overlap > order > timeout):
//   - overlap (2): two or more of registered pump/MW/probe high at once.
//   - order (1): rising edge of any signal not expected in the current state,
//     or a sample rise outside PROBE.
//   - timeout (3): state dwell counter reaches TIMEOUT.
//   - On error: seq_error=1 for 1 cycle, error_code latched (held until next meas_valid),
//     FSM -> IDLE, *_len/sample_count hold their previous values, no meas_valid.
//   - Sample rise in IDLE is ignored (no error).
//  Reset mid-sequence aborts silently: no seq_error, no meas_valid.
// TESTING
//  1. Nominal sequence: pump 10, gap 5, MW 25, gap 100, MW 25, gap 5, probe 20 with 3 sample pulses
//     -> meas_valid once; lengths 10/25/100/25/20; sample_count=3; good_count=1; error_code=0.
//  2. Repeat test 1 back-to-back with a precession gap of 102
//     -> second meas_valid; freeprecess_len=102; good_count=2.
//  3. MW rises while pump is still high -> seq_error pulse; error_code=2; no meas_valid;
//     lengths unchanged; FSM returns to IDLE.
//  4. TIMEOUT=50; pump 10 cycles, then all inputs idle -> seq_error exactly 50 cycles after entering GAP1;
//     error_code=3.
//  5. Sample pulse during GAP2 -> error_code=1. The next nominal sequence then gives meas_valid
//     and error_code=0.
//  6. Reset low for 10 cycles mid-PRECESS, with pump held high across the release -> all outputs 0;
//     no edge detected; a subsequent nominal sequence measures correctly with good_count=1.

Source files
------------

// File: rtl/pop_sequence_monitor.sv
// ---------------------------------------------------------------------------
// pop_sequence_monitor
//
// Receive-side checker for the POP timing outputs on the 2.5 MHz domain.
// Follows one pump -> MW(pi/2) -> free precession -> MW(pi/2) -> probe
// sequence at a time and measures each pulse width and the precession gap
// in clock cycles. A complete sequence is reported with a one-cycle
// meas_valid strobe. An ordering, overlap or timeout error gives a
// one-cycle seq_error strobe and a latched error_code instead.
//
// Ports
//   clk_2M5          in   1      2.5 MHz clock, the only clock
//   reset            in   1      synchronous, active-low reset
//   pump, MW, probe  in   1      pulses under test
//   sample           in   1      sample strobe, counted only inside PROBE
//   pump_len         out  WIDTH  cycles pump was high
//   pieovertwo_len   out  WIDTH  cycles of the first MW pulse
//   freeprecess_len  out  WIDTH  cycles from first MW fall to second MW rise
//   mw2_len          out  WIDTH  cycles of the second MW pulse
//   probe_len        out  WIDTH  cycles probe was high
//   sample_count     out  8      sample rises during probe, saturating
//   meas_valid       out  1      1-cycle strobe, all measurements updated
//   seq_error        out  1      1-cycle strobe on any error
//   error_code       out  2      0 none, 1 order, 2 overlap, 3 timeout
//   good_count       out  WIDTH  number of valid sequences, wraps
// ---------------------------------------------------------------------------
module pop_sequence_monitor #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 20000
) (
    input  logic             clk_2M5,
    input  logic             reset,
    input  logic             pump,
    input  logic             MW,
    input  logic             probe,
    input  logic             sample,
    output logic [WIDTH-1:0] pump_len,
    output logic [WIDTH-1:0] pieovertwo_len,
    output logic [WIDTH-1:0] freeprecess_len,
    output logic [WIDTH-1:0] mw2_len,
    output logic [WIDTH-1:0] probe_len,
    output logic [7:0]       sample_count,
    output logic             meas_valid,
    output logic             seq_error,
    output logic [1:0]       error_code,
    output logic [WIDTH-1:0] good_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_PUMP, S_GAP1, S_MW1, S_PRECESS, S_MW2, S_GAP2, S_PROBE, S_REPORT
    } state_t;

    localparam int IN_PUMP   = 0;
    localparam int IN_MW     = 1;
    localparam int IN_PROBE  = 2;
    localparam int IN_SAMPLE = 3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ORDER   = 2'd1;
    localparam logic [1:0] ERR_OVERLAP = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [WIDTH-1:0] LEN_MAX     = '1;
    localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);

    state_t           state, state_next;
    logic [3:0]       in_q, in_hist;     // {sample, probe, MW, pump}
    logic [3:0]       rise, exp_rise;
    logic [2:0]       fall;
    logic             overlap, advance;
    logic [1:0]       err;
    logic [WIDTH-1:0] run_cnt;           // cycles spent in the current state
    logic [WIDTH-1:0] pend_pump, pend_mw1, pend_prec, pend_mw2, pend_probe;
    logic [7:0]       pend_samples;

    // NOTE: the input stage is deliberately left out of reset. It keeps
    // sampling while reset is low, so a level held across the release
    // leaves history equal to the registered value and produces no edge.
    always_ff @(posedge clk_2M5) begin
        // NOTE: non-blocking assignments make in_hist take the old in_q,
        // which is exactly the one-cycle history needed for edge detection.
        in_q    <= {sample, probe, MW, pump};
        in_hist <= in_q;
    end

    assign rise    = in_q & ~in_hist;
    assign fall    = ~in_q[2:0] & in_hist[2:0];
    assign overlap = (in_q[IN_PUMP] & in_q[IN_MW])  |
                     (in_q[IN_PUMP] & in_q[IN_PROBE]) |
                     (in_q[IN_MW]   & in_q[IN_PROBE]);

    // Every state holds one measured level until its exit edge, so the
    // dwell counter doubles as the length counter for that state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no
        // path through the case statement can infer a latch.
        state_next = state;
        exp_rise   = 4'b0000;
        advance    = 1'b0;
        err        = ERR_NONE;

        case (state)
            S_IDLE:    if (rise[IN_PUMP]) state_next = S_PUMP;
            S_PUMP:    begin
                advance = fall[IN_PUMP];
                if (advance) state_next = S_GAP1;
            end
            S_GAP1:    begin
                exp_rise[IN_MW] = 1'b1;
                advance = rise[IN_MW];
                if (advance) state_next = S_MW1;
            end
            S_MW1:     begin
                advance = fall[IN_MW];
                if (advance) state_next = S_PRECESS;
            end
            S_PRECESS: begin
                exp_rise[IN_MW] = 1'b1;
                advance = rise[IN_MW];
                if (advance) state_next = S_MW2;
            end
            S_MW2:     begin
                advance = fall[IN_MW];
                if (advance) state_next = S_GAP2;
            end
            S_GAP2:    begin
                exp_rise[IN_PROBE] = 1'b1;
                advance = rise[IN_PROBE];
                if (advance) state_next = S_PROBE;
            end
            S_PROBE:   begin
                exp_rise[IN_SAMPLE] = 1'b1;
                advance = fall[IN_PROBE];
                if (advance) state_next = S_REPORT;
            end
            default:   state_next = S_IDLE;   // S_REPORT lasts one cycle
        endcase

        // Errors pre-empt any transition on the same edge.
        if (state != S_IDLE && state != S_REPORT) begin
            if (overlap)                    err = ERR_OVERLAP;
            else if (|(rise & ~exp_rise))   err = ERR_ORDER;
            else if (run_cnt == TIMEOUT_CNT) err = ERR_TIMEOUT;
            if (err != ERR_NONE) state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk_2M5) begin
        if (!reset) begin
            state           <= S_IDLE;
            run_cnt         <= '0;
            pend_pump       <= '0;
            pend_mw1        <= '0;
            pend_prec       <= '0;
            pend_mw2        <= '0;
            pend_probe      <= '0;
            pend_samples    <= '0;
            pump_len        <= '0;
            pieovertwo_len  <= '0;
            freeprecess_len <= '0;
            mw2_len         <= '0;
            probe_len       <= '0;
            sample_count    <= '0;
            meas_valid      <= 1'b0;
            seq_error       <= 1'b0;
            error_code      <= ERR_NONE;
            good_count      <= '0;
        end else begin
            state      <= state_next;
            meas_valid <= 1'b0;
            seq_error  <= 1'b0;

            if (state_next != state)  run_cnt <= WIDTH'(1);
            else if (run_cnt != LEN_MAX) run_cnt <= run_cnt + 1'b1;

            if (err != ERR_NONE) begin
                seq_error  <= 1'b1;
                error_code <= err;
            end else begin
                if (advance) begin
                    case (state)
                        S_PUMP:    pend_pump  <= run_cnt;
                        S_MW1:     pend_mw1   <= run_cnt;
                        S_PRECESS: pend_prec  <= run_cnt;
                        S_MW2:     pend_mw2   <= run_cnt;
                        S_PROBE:   pend_probe <= run_cnt;
                        default:   ;
                    endcase
                end
                if (state == S_IDLE && state_next == S_PUMP)
                    pend_samples <= '0;
                if (state == S_PROBE && rise[IN_SAMPLE] && pend_samples != 8'hFF)
                    pend_samples <= pend_samples + 1'b1;
                if (state == S_REPORT) begin
                    meas_valid      <= 1'b1;
                    pump_len        <= pend_pump;
                    pieovertwo_len  <= pend_mw1;
                    freeprecess_len <= pend_prec;
                    mw2_len         <= pend_mw2;
                    probe_len       <= pend_probe;
                    sample_count    <= pend_samples;
                    good_count      <= good_count + 1'b1;
                    error_code      <= ERR_NONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_pop_sequence_monitor.sv
// ---------------------------------------------------------------------------
// tb_pop_sequence_monitor
//
// Drives directed POP sequences into two monitors that share their inputs:
// one with the default timeout and one with TIMEOUT=50. Each is compared
// every cycle against an event-list model: the expected edge order is a
// list, lengths come from differences of edge timestamps. Literal values
// for the directed scenarios pin both the model and the DUT.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pop_sequence_monitor;

    localparam int W      = 16;
    localparam int TO_DEF = 20000;
    localparam int TO_SH  = 50;

    logic clk_2M5 = 1'b0;
    logic reset   = 1'b0;
    logic pump = 1'b0, mw = 1'b0, probe = 1'b0, sample = 1'b0;

    logic [W-1:0] pump_len [2];
    logic [W-1:0] mw1_len  [2];
    logic [W-1:0] prec_len [2];
    logic [W-1:0] mw2_len  [2];
    logic [W-1:0] probe_len[2];
    logic [7:0]   samp_cnt [2];
    logic         meas_valid[2];
    logic         seq_error [2];
    logic [1:0]   error_code[2];
    logic [W-1:0] good_count[2];

    int checks   = 0;
    int failures = 0;
    int mv_pulses = 0;
    int se_pulses = 0;

    always #200 clk_2M5 = ~clk_2M5;

    pop_sequence_monitor #(.WIDTH(W), .TIMEOUT(TO_DEF)) dut (
        .clk_2M5(clk_2M5), .reset(reset),
        .pump(pump), .MW(mw), .probe(probe), .sample(sample),
        .pump_len(pump_len[0]), .pieovertwo_len(mw1_len[0]),
        .freeprecess_len(prec_len[0]), .mw2_len(mw2_len[0]),
        .probe_len(probe_len[0]), .sample_count(samp_cnt[0]),
        .meas_valid(meas_valid[0]), .seq_error(seq_error[0]),
        .error_code(error_code[0]), .good_count(good_count[0])
    );

    pop_sequence_monitor #(.WIDTH(W), .TIMEOUT(TO_SH)) dut_to (
        .clk_2M5(clk_2M5), .reset(reset),
        .pump(pump), .MW(mw), .probe(probe), .sample(sample),
        .pump_len(pump_len[1]), .pieovertwo_len(mw1_len[1]),
        .freeprecess_len(prec_len[1]), .mw2_len(mw2_len[1]),
        .probe_len(probe_len[1]), .sample_count(samp_cnt[1]),
        .meas_valid(meas_valid[1]), .seq_error(seq_error[1]),
        .error_code(error_code[1]), .good_count(good_count[1])
    );

    // ---------------- behavioural model ----------------
    // k indexes the next expected edge in the list
    //   0 pump rise, 1 pump fall, 2 MW rise, 3 MW fall,
    //   4 MW rise,   5 MW fall,   6 probe rise, 7 probe fall
    // t[k] is the cycle number at which edge k was seen.
    typedef struct {
        int k;
        bit rpt;
        int t[8];
        int tlast;
        int samples;
        int pump_len, mw1_len, prec_len, mw2_len, probe_len, sample_count;
        bit mv, se;
        int ec;
        int gc;
    } mdl_t;

    mdl_t md[2];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sig_of(input int k);
        if (k < 2) return 0;
        if (k < 6) return 1;
        return 2;
    endfunction

    task automatic model_step(input int m, input int n, input int to,
                              input logic rst, input logic [3:0] c, input logic [3:0] p);
        logic [3:0] rise, fall, exp_r;
        int code, s;
        bit hit;
        rise = c & ~p;
        fall = ~c & p;
        md[m].mv = 0;
        md[m].se = 0;
        if (!rst) begin
            md[m].k = 0; md[m].rpt = 0; md[m].samples = 0;
            md[m].pump_len = 0; md[m].mw1_len = 0; md[m].prec_len = 0;
            md[m].mw2_len = 0; md[m].probe_len = 0; md[m].sample_count = 0;
            md[m].ec = 0; md[m].gc = 0;
        end else if (md[m].rpt) begin
            md[m].pump_len     = md[m].t[1] - md[m].t[0];
            md[m].mw1_len      = md[m].t[3] - md[m].t[2];
            md[m].prec_len     = md[m].t[4] - md[m].t[3];
            md[m].mw2_len      = md[m].t[5] - md[m].t[4];
            md[m].probe_len    = md[m].t[7] - md[m].t[6];
            md[m].sample_count = md[m].samples;
            md[m].gc           = (md[m].gc + 1) % 65536;
            md[m].ec = 0;
            md[m].mv = 1;
            md[m].rpt = 0;
            md[m].k = 0;
        end else if (md[m].k == 0) begin
            if (rise[0]) begin
                md[m].t[0] = n; md[m].tlast = n; md[m].k = 1; md[m].samples = 0;
            end
        end else begin
            s = sig_of(md[m].k);
            exp_r = 4'b0000;
            if (md[m].k % 2 == 0) exp_r[s] = 1'b1;
            if (md[m].k == 7) exp_r[3] = 1'b1;
            code = 0;
            if ($countones(c[2:0]) >= 2)        code = 2;
            else if ((rise & ~exp_r) != 4'b0)   code = 1;
            else if (n - md[m].tlast == to)     code = 3;
            if (code != 0) begin
                md[m].se = 1; md[m].ec = code; md[m].k = 0;
            end else begin
                if (md[m].k == 7 && rise[3] && md[m].samples < 255) md[m].samples++;
                hit = (md[m].k % 2 == 1) ? fall[s] : rise[s];
                if (hit) begin
                    md[m].t[md[m].k] = n;
                    md[m].tlast = n;
                    if (md[m].k == 7) md[m].rpt = 1;
                    else md[m].k++;
                end
            end
        end
    endtask

    function automatic logic [127:0] exp_vec(input int m);
        return {20'b0, 16'(md[m].pump_len), 16'(md[m].mw1_len), 16'(md[m].prec_len),
                16'(md[m].mw2_len), 16'(md[m].probe_len), 8'(md[m].sample_count),
                md[m].mv, md[m].se, 2'(md[m].ec), 16'(md[m].gc)};
    endfunction

    function automatic logic [127:0] act_vec(input int m);
        return {20'b0, pump_len[m], mw1_len[m], prec_len[m], mw2_len[m], probe_len[m],
                samp_cnt[m], meas_valid[m], seq_error[m], error_code[m], good_count[m]};
    endfunction

    // One compare process: model advances on the rising edge, outputs are
    // compared on the falling edge.
    initial begin
        logic [3:0] pins_d1, pins_d2;
        int n;
        pins_d1 = 4'b0; pins_d2 = 4'b0; n = 0;
        forever begin
            @(posedge clk_2M5);
            n++;
            model_step(0, n, TO_DEF, reset, pins_d1, pins_d2);
            model_step(1, n, TO_SH,  reset, pins_d1, pins_d2);
            pins_d2 = pins_d1;
            pins_d1 = {sample, probe, mw, pump};
            @(negedge clk_2M5);
            check("cycle_dut",    act_vec(0), exp_vec(0));
            check("cycle_dut_to", act_vec(1), exp_vec(1));
            if (meas_valid[0]) mv_pulses++;
            if (seq_error[0])  se_pulses++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_2M5);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input int cycles);
        {sample, probe, mw, pump} = v;
        repeat (cycles) tick();
    endtask

    task automatic nominal(input int prec, input bit gap2_sample);
        drive(4'b0001, 10);
        drive(4'b0000, 5);
        drive(4'b0010, 25);
        drive(4'b0000, prec);
        drive(4'b0010, 25);
        if (gap2_sample) begin
            drive(4'b0000, 2); drive(4'b1000, 1); drive(4'b0000, 2);
        end else begin
            drive(4'b0000, 5);
        end
        drive(4'b0100, 3);
        repeat (3) begin
            drive(4'b1100, 1);
            drive(4'b0100, 4);
        end
        drive(4'b0100, 2);
        drive(4'b0000, 5);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int mv0, se0, lat;
        reset = 1'b0;
        repeat (5) tick();
        check("reset_good_count", 128'(good_count[0]), 128'(0));
        check("reset_error_code", 128'(error_code[0]), 128'(0));
        reset = 1'b1;
        repeat (5) tick();

        // 1: nominal sequence
        mv0 = mv_pulses;
        nominal(100, 1'b0);
        check("t1_meas_valid_count", 128'(mv_pulses - mv0), 128'(1));
        check("t1_pump_len",  128'(pump_len[0]),  128'(10));
        check("t1_mw1_len",   128'(mw1_len[0]),   128'(25));
        check("t1_prec_len",  128'(prec_len[0]),  128'(100));
        check("t1_mw2_len",   128'(mw2_len[0]),   128'(25));
        check("t1_probe_len", 128'(probe_len[0]), 128'(20));
        check("t1_samples",   128'(samp_cnt[0]),  128'(3));
        check("t1_good",      128'(good_count[0]), 128'(1));
        check("t1_err_code",  128'(error_code[0]), 128'(0));
        check("t1_model_prec",  128'(md[0].prec_len),  128'(100));
        check("t1_model_probe", 128'(md[0].probe_len), 128'(20));
        check("t1_to_err_code", 128'(error_code[1]), 128'(3));

        // 2: back-to-back, longer precession
        mv0 = mv_pulses;
        nominal(102, 1'b0);
        check("t2_meas_valid_count", 128'(mv_pulses - mv0), 128'(1));
        check("t2_prec_len", 128'(prec_len[0]),   128'(102));
        check("t2_good",     128'(good_count[0]), 128'(2));

        // 3: MW rises while pump is still high
        mv0 = mv_pulses; se0 = se_pulses;
        drive(4'b0001, 5);
        drive(4'b0011, 3);
        drive(4'b0000, 10);
        check("t3_seq_error_count", 128'(se_pulses - se0), 128'(1));
        check("t3_err_code",  128'(error_code[0]), 128'(2));
        check("t3_no_meas",   128'(mv_pulses - mv0), 128'(0));
        check("t3_pump_held", 128'(pump_len[0]),   128'(10));
        check("t3_prec_held", 128'(prec_len[0]),   128'(102));
        check("t3_good_held", 128'(good_count[0]), 128'(2));

        // 5: sample pulse during GAP2, then a clean sequence
        mv0 = mv_pulses; se0 = se_pulses;
        nominal(100, 1'b1);
        check("t5_seq_error_count", 128'(se_pulses - se0), 128'(1));
        check("t5_err_code", 128'(error_code[0]), 128'(1));
        check("t5_no_meas",  128'(mv_pulses - mv0), 128'(0));
        nominal(100, 1'b0);
        check("t5_meas_after",   128'(mv_pulses - mv0), 128'(1));
        check("t5_err_cleared",  128'(error_code[0]), 128'(0));
        check("t5_good",         128'(good_count[0]), 128'(3));

        // 4: timeout on the TIMEOUT=50 instance
        drive(4'b0000, 10);
        drive(4'b0001, 10);
        {sample, probe, mw, pump} = 4'b0000;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (seq_error[1]) begin
                lat = i;
                break;
            end
        end
        // pin low sampled 1 edge later, fall seen 2 edges later, then 50 in GAP1
        check("t4_timeout_latency", 128'(lat), 128'(52));
        check("t4_err_code",        128'(error_code[1]), 128'(3));
        drive(4'b0000, 5);
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        drive(4'b0000, 5);

        // 6: reset mid-PRECESS with pump held high across the release
        mv0 = mv_pulses; se0 = se_pulses;
        drive(4'b0001, 10);
        drive(4'b0000, 5);
        drive(4'b0010, 25);
        drive(4'b0000, 30);
        reset = 1'b0;
        drive(4'b0001, 10);
        check("t6_rst_pump_len", 128'(pump_len[0]),   128'(0));
        check("t6_rst_samples",  128'(samp_cnt[0]),   128'(0));
        check("t6_rst_good",     128'(good_count[0]), 128'(0));
        check("t6_rst_err",      128'(error_code[0]), 128'(0));
        check("t6_rst_strobes",  128'({meas_valid[0], seq_error[0]}), 128'(0));
        reset = 1'b1;
        drive(4'b0001, 5);
        drive(4'b0000, 10);
        check("t6_no_seq_error", 128'(se_pulses - se0), 128'(0));
        check("t6_no_meas",      128'(mv_pulses - mv0), 128'(0));
        nominal(100, 1'b0);
        check("t6_meas_count", 128'(mv_pulses - mv0), 128'(1));
        check("t6_good",       128'(good_count[0]), 128'(1));
        check("t6_pump_len",   128'(pump_len[0]),   128'(10));
        check("t6_mw1_len",    128'(mw1_len[0]),    128'(25));
        check("t6_prec_len",   128'(prec_len[0]),   128'(100));
        check("t6_mw2_len",    128'(mw2_len[0]),    128'(25));
        check("t6_probe_len",  128'(probe_len[0]),  128'(20));
        check("t6_samples",    128'(samp_cnt[0]),   128'(3));
        drive(4'b0000, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
